// File: rtl/src_arb_pkg.sv
// Shared types and constants for the two-channel source arbiter.
package src_arb_pkg;

  localparam int unsigned WORD_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/src_arb.sv
// Shares one encoder input between two channel FIFOs, switching ownership
// only at block boundaries with round-robin fairness.
module src_arb
  import src_arb_pkg::*;
#(
  parameter int unsigned LZF_WIDTH = 20,
  parameter int unsigned LZF_DEBUG = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ch0_empty,
  input  logic [WORD_W-1:0]    ch0_data,
  input  logic                 ch0_last,
  output logic                 ch0_getn,
  input  logic                 ch1_empty,
  input  logic [WORD_W-1:0]    ch1_data,
  input  logic                 ch1_last,
  output logic                 ch1_getn,
  input  logic                 m_src_getn,
  input  logic                 m_endn,
  output logic                 src_empty,
  output logic [WORD_W-1:0]    fi,
  output logic                 m_last,
  output logic                 owner,
  output logic                 busy,
  output logic [LZF_WIDTH-1:0] fi_cnt
);

  state_t            state;
  logic              ptr;
  logic              own_empty;
  logic              own_last;
  logic [WORD_W-1:0] own_data;
  logic              xfer;
  logic              active;
  logic              pop;

  always_comb begin
    own_empty = owner ? ch1_empty : ch0_empty;
    own_last  = owner ? ch1_last  : ch0_last;
    own_data  = owner ? ch1_data  : ch0_data;
  end

  // rst gates the combinational outputs so no pop can leak out in the reset cycle.
  assign xfer   = (state == ST_XFER) && !rst;
  assign active = (state != ST_IDLE) && !rst;
  assign pop    = xfer && !m_src_getn && !own_empty;

  always_comb begin
    src_empty = !xfer || own_empty;
    ch0_getn  = !(pop && !owner);
    ch1_getn  = !(pop && owner);
    fi        = active ? own_data : '0;
    m_last    = active && own_last;
    busy      = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      owner  <= 1'b0;
      ptr    <= 1'b0;
      fi_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!ch0_empty || !ch1_empty) begin
            // On a tie ptr decides; otherwise ch0_empty=1 means ch1 is the requester.
            owner  <= (!ch0_empty && !ch1_empty) ? ptr : ch0_empty;
            fi_cnt <= '0;
            state  <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (pop) begin
            if (fi_cnt != '1)
              fi_cnt <= fi_cnt + LZF_WIDTH'(1);
            if (own_last)
              state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!m_endn) begin
            ptr   <= ~owner;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  if (LZF_DEBUG != 0) begin : g_dbg
    always_ff @(posedge clk) begin
      if (!rst && state == ST_IDLE && (!ch0_empty || !ch1_empty))
        $write("[src_arb] grant ch%0d\n", (!ch0_empty && !ch1_empty) ? ptr : ch0_empty);
      if (!rst && state == ST_DRAIN && !m_endn)
        $write("[src_arb] block end ch%0d words=%0d\n", owner, fi_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_src_arb.sv
// Directed table-driven bench for src_arb, with a narrow-counter twin for saturation.
module tb_src_arb;

  localparam logic [63:0] D0 = 64'h0706050403020100;
  localparam logic [63:0] D1 = 64'h8F8E8D8C8B8A8988;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ch0_empty = 1'b1, ch0_last = 1'b0;
  logic        ch1_empty = 1'b1, ch1_last = 1'b0;
  logic [63:0] ch0_data = D0, ch1_data = D1;
  logic        m_src_getn = 1'b1, m_endn = 1'b1;

  logic        ch0_getn, ch1_getn, src_empty, m_last, owner, busy;
  logic [63:0] fi;
  logic [19:0] fi_cnt;
  logic        n_ch0_getn, n_ch1_getn, n_src_empty, n_m_last, n_owner, n_busy;
  logic [63:0] n_fi;
  logic [1:0]  n_fi_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  src_arb #(.LZF_WIDTH(20), .LZF_DEBUG(0)) dut (
    .clk(clk), .rst(rst),
    .ch0_empty(ch0_empty), .ch0_data(ch0_data), .ch0_last(ch0_last), .ch0_getn(ch0_getn),
    .ch1_empty(ch1_empty), .ch1_data(ch1_data), .ch1_last(ch1_last), .ch1_getn(ch1_getn),
    .m_src_getn(m_src_getn), .m_endn(m_endn), .src_empty(src_empty), .fi(fi),
    .m_last(m_last), .owner(owner), .busy(busy), .fi_cnt(fi_cnt)
  );

  src_arb #(.LZF_WIDTH(2), .LZF_DEBUG(0)) dut_n (
    .clk(clk), .rst(rst),
    .ch0_empty(ch0_empty), .ch0_data(ch0_data), .ch0_last(ch0_last), .ch0_getn(n_ch0_getn),
    .ch1_empty(ch1_empty), .ch1_data(ch1_data), .ch1_last(ch1_last), .ch1_getn(n_ch1_getn),
    .m_src_getn(m_src_getn), .m_endn(m_endn), .src_empty(n_src_empty), .fi(n_fi),
    .m_last(n_m_last), .owner(n_owner), .busy(n_busy), .fi_cnt(n_fi_cnt)
  );

  typedef struct {
    logic rst, e0, l0, e1, l1, g, en;
    logic se, g0, g1, own, bsy;
    int   cnt;
    logic ml;
    int   fsel;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst_i, logic e0, logic l0, logic e1, logic l1,
                              logic g, logic en, logic se, logic g0, logic g1,
                              logic own, logic bsy, int cnt, logic ml, int fsel);
    vec_t v;
    v.rst = rst_i; v.e0 = e0; v.l0 = l0; v.e1 = e1; v.l1 = l1; v.g = g; v.en = en;
    v.se = se; v.g0 = g0; v.g1 = g1; v.own = own; v.bsy = bsy;
    v.cnt = cnt; v.ml = ml; v.fsel = fsel;
    return v;
  endfunction

  task automatic check_bit(string name, logic got, logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  initial begin
    logic [63:0] exp_fi;
    int          exp_ncnt;
    int          npop;
    bit          reached;

    //        rst e0 l0 e1 l1 g en | se g0 g1 own bsy cnt ml fsel
    vecs.push_back(mk(1, 1,0, 1,0, 1,1,  1,1,1, 0,0, 0, 0,0)); // r0 reset idle
    vecs.push_back(mk(0, 0,0, 1,0, 1,1,  1,1,1, 0,0, 0, 0,0)); // r1 ch0 requests
    vecs.push_back(mk(0, 0,0, 1,0, 0,1,  0,0,1, 0,1, 0, 0,1)); // r2 pop 1
    vecs.push_back(mk(0, 0,0, 1,0, 0,1,  0,0,1, 0,1, 1, 0,1)); // r3 pop 2
    vecs.push_back(mk(0, 0,1, 1,0, 0,1,  0,0,1, 0,1, 2, 1,1)); // r4 pop 3 last
    vecs.push_back(mk(0, 1,0, 1,0, 0,1,  1,1,1, 0,1, 3, 0,1)); // r5 drain, pops ignored
    vecs.push_back(mk(0, 1,0, 1,0, 0,0,  1,1,1, 0,1, 3, 0,1)); // r6 endn
    vecs.push_back(mk(0, 1,0, 1,0, 1,1,  1,1,1, 0,0, 3, 0,0)); // r7 idle
    vecs.push_back(mk(0, 0,0, 0,0, 1,1,  1,1,1, 0,0, 3, 0,0)); // r8 tie, ptr=1
    vecs.push_back(mk(0, 0,0, 0,1, 0,1,  0,1,0, 1,1, 0, 1,2)); // r9 ch1 single word
    vecs.push_back(mk(0, 0,0, 0,0, 1,0,  1,1,1, 1,1, 1, 0,2)); // r10 drain end
    vecs.push_back(mk(0, 0,0, 0,0, 1,1,  1,1,1, 1,0, 1, 0,0)); // r11 tie, ptr=0
    vecs.push_back(mk(0, 0,1, 0,0, 0,1,  0,0,1, 0,1, 0, 1,1)); // r12 ch0 single word
    vecs.push_back(mk(0, 0,0, 0,0, 1,0,  1,1,1, 0,1, 1, 0,1)); // r13 drain end
    vecs.push_back(mk(0, 0,0, 0,0, 1,1,  1,1,1, 0,0, 1, 0,0)); // r14 tie, ptr=1
    vecs.push_back(mk(0, 0,0, 0,0, 1,0,  0,1,1, 1,1, 0, 0,2)); // r15 endn in XFER ignored
    vecs.push_back(mk(0, 0,0, 0,1, 0,1,  0,1,0, 1,1, 0, 1,2)); // r16 ch1 last
    vecs.push_back(mk(0, 0,0, 0,0, 1,0,  1,1,1, 1,1, 1, 0,2)); // r17 drain end
    vecs.push_back(mk(0, 0,0, 1,0, 1,1,  1,1,1, 1,0, 1, 0,0)); // r18 ch0 only
    vecs.push_back(mk(0, 0,0, 1,0, 0,1,  0,0,1, 0,1, 0, 0,1)); // r19 pop 1
    vecs.push_back(mk(0, 1,0, 1,0, 0,1,  1,1,1, 0,1, 1, 0,1)); // r20 underrun
    vecs.push_back(mk(0, 1,0, 1,0, 0,1,  1,1,1, 0,1, 1, 0,1)); // r21 underrun
    vecs.push_back(mk(0, 0,0, 1,0, 0,1,  0,0,1, 0,1, 1, 0,1)); // r22 refill pop 2
    vecs.push_back(mk(0, 0,0, 0,0, 0,1,  0,0,1, 0,1, 2, 0,1)); // r23 ch1 fills, pop 3
    vecs.push_back(mk(0, 0,0, 0,0, 0,1,  0,0,1, 0,1, 3, 0,1)); // r24 pop 4
    vecs.push_back(mk(0, 0,0, 0,0, 0,1,  0,0,1, 0,1, 4, 0,1)); // r25 pop 5
    vecs.push_back(mk(0, 0,1, 0,0, 0,1,  0,0,1, 0,1, 5, 1,1)); // r26 pop 6 last
    vecs.push_back(mk(0, 0,0, 0,0, 1,0,  1,1,1, 0,1, 6, 0,1)); // r27 drain end
    vecs.push_back(mk(0, 0,0, 0,0, 1,1,  1,1,1, 0,0, 6, 0,0)); // r28 tie -> ch1
    vecs.push_back(mk(0, 0,0, 0,1, 0,1,  0,1,0, 1,1, 0, 1,2)); // r29 ch1 last
    vecs.push_back(mk(0, 1,0, 0,0, 1,0,  1,1,1, 1,1, 1, 0,2)); // r30 drain end, ptr=0
    vecs.push_back(mk(0, 1,0, 0,0, 1,1,  1,1,1, 1,0, 1, 0,0)); // r31 ch1 only, back-to-back
    vecs.push_back(mk(0, 1,0, 0,0, 0,1,  0,1,0, 1,1, 0, 0,2)); // r32 pop 1
    vecs.push_back(mk(1, 1,0, 0,0, 0,1,  1,1,1, 1,1, 1, 0,0)); // r33 reset mid-XFER
    vecs.push_back(mk(1, 1,0, 0,0, 0,1,  1,1,1, 0,0, 0, 0,0)); // r34
    vecs.push_back(mk(1, 1,0, 0,0, 0,1,  1,1,1, 0,0, 0, 0,0)); // r35
    vecs.push_back(mk(1, 1,0, 0,0, 0,1,  1,1,1, 0,0, 0, 0,0)); // r36
    vecs.push_back(mk(0, 1,0, 1,0, 1,1,  1,1,1, 0,0, 0, 0,0)); // r37 post-reset idle

    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      ch0_empty = vecs[i].e0; ch0_last = vecs[i].l0;
      ch1_empty = vecs[i].e1; ch1_last = vecs[i].l1;
      m_src_getn = vecs[i].g; m_endn = vecs[i].en;
      #2;
      exp_fi = (vecs[i].fsel == 1) ? D0 : (vecs[i].fsel == 2) ? D1 : 64'd0;
      exp_ncnt = (vecs[i].cnt > 3) ? 3 : vecs[i].cnt;
      tests++;
      if (src_empty !== vecs[i].se || ch0_getn !== vecs[i].g0 || ch1_getn !== vecs[i].g1 ||
          owner !== vecs[i].own || busy !== vecs[i].bsy || fi_cnt !== 20'(vecs[i].cnt) ||
          m_last !== vecs[i].ml || fi !== exp_fi) begin
        fails++;
        $display("FAIL row%0d: got se=%b g0=%b g1=%b own=%b busy=%b cnt=%0d ml=%b fi=%h want se=%b g0=%b g1=%b own=%b busy=%b cnt=%0d ml=%b fi=%h",
                 i, src_empty, ch0_getn, ch1_getn, owner, busy, fi_cnt, m_last, fi,
                 vecs[i].se, vecs[i].g0, vecs[i].g1, vecs[i].own, vecs[i].bsy,
                 vecs[i].cnt, vecs[i].ml, exp_fi);
      end
      tests++;
      if (n_fi_cnt !== 2'(exp_ncnt) || n_owner !== vecs[i].own) begin
        fails++;
        $display("FAIL row%0d_narrow: got cnt=%0d own=%b want cnt=%0d own=%b",
                 i, n_fi_cnt, n_owner, exp_ncnt, vecs[i].own);
      end
    end

    // Streamed 3-word ch0 block: encoder pops continuously until DRAIN shows up.
    npop = 0;
    reached = 1'b0;
    for (int c = 0; c < 12 && !reached; c++) begin
      @(negedge clk);
      ch0_empty = 1'b0; ch1_empty = 1'b1;
      ch0_last = (npop == 2);
      m_src_getn = 1'b0; m_endn = 1'b1;
      #2;
      if (busy && src_empty && npop == 3) reached = 1'b1;
      else if (!ch0_getn) npop++;
    end
    check_bit("stream_reach_drain", reached, 1'b1);
    tests++;
    if (fi_cnt !== 20'd3) begin
      fails++;
      $display("FAIL stream_cnt: got %0d want 3", fi_cnt);
    end
    check_bit("stream_getn_drain", ch0_getn, 1'b1);

    @(negedge clk);
    ch0_empty = 1'b1; ch0_last = 1'b0; m_src_getn = 1'b1; m_endn = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 5 && !reached; c++) begin
      @(negedge clk);
      m_endn = 1'b1;
      #2;
      if (!busy) reached = 1'b1;
    end
    check_bit("stream_back_idle", reached, 1'b1);

    // ptr must now favour ch1 on a tie.
    @(negedge clk);
    ch0_empty = 1'b0; ch1_empty = 1'b0;
    @(negedge clk);
    #2;
    check_bit("stream_next_owner", owner, 1'b1);
    check_bit("stream_next_src_empty", src_empty, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
